// File: rtl/pe_stream_feeder_if.sv
// Word stream carrying valid/ready handshaking, with an optional last marker.
// The feeder consumes the input stream through the slave modport and drives the output stream
// through the master modport.
interface pe_stream_feeder_if #(
    parameter int unsigned WORD_LEN = 16
) ();
    logic                valid;
    logic                ready;
    logic [WORD_LEN-1:0] data;
    logic                last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pe_stream_feeder.sv
// Sequencer that loads one PE's D and W buses from a word stream, pulses its compute enable,
// and then drains its Q words back out onto a stream.
module pe_stream_feeder #(
    parameter int unsigned WORD_LEN = 16,
    parameter int unsigned NEU_IN   = 16,
    parameter int unsigned NEU_OUT  = 4,
    parameter int unsigned PE_LAT   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [1:0]                           mode_in,
    input  logic                                 reuse_w,
    output logic                                 busy,
    output logic                                 done,
    pe_stream_feeder_if.slave                    in_s,
    pe_stream_feeder_if.master                   out_s,
    output logic                                 pe_ce,
    output logic [1:0]                           pe_mode,
    output logic [WORD_LEN*NEU_IN-1:0]           pe_d,
    output logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]   pe_w,
    input  logic [WORD_LEN*NEU_IN*NEU_OUT/2-1:0] pe_q
);
    localparam int unsigned NW      = NEU_IN * NEU_OUT;
    localparam int unsigned NQ      = NW / 2;
    localparam int unsigned MAX_CNT = (PE_LAT > NW) ? PE_LAT : NW;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int unsigned DIDX_W  = $clog2(NEU_IN);
    localparam int unsigned WIDX_W  = $clog2(NW);
    localparam int unsigned QIDX_W  = $clog2(NQ);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_D = 3'd1;
    localparam logic [2:0] S_LOAD_W = 3'd2;
    localparam logic [2:0] S_FIRE   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]                         state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [1:0]                         mode_q, mode_d;
    logic                               reuse_q, reuse_d;
    logic                               done_q, done_d;
    logic [WORD_LEN*NEU_IN-1:0]         pe_d_q;
    logic [WORD_LEN*NEU_IN*NEU_OUT-1:0] pe_w_q;

    logic              in_hs, out_hs;
    logic [CNT_W-1:0]  last_idx;
    logic [DIDX_W-1:0] d_idx;
    logic [WIDX_W-1:0] w_idx;
    logic [QIDX_W-1:0] q_idx;

    // One counter serves as load word index, fire cycle count and drain word index.
    assign d_idx = cnt_q[DIDX_W-1:0];
    assign w_idx = cnt_q[WIDX_W-1:0];
    assign q_idx = cnt_q[QIDX_W-1:0];

    assign in_s.ready = (state_q == S_LOAD_D) || (state_q == S_LOAD_W);
    assign in_hs      = in_s.valid && in_s.ready;

    // Mode 00 returns every packed Q word; other modes return one word per output neuron.
    assign last_idx    = (mode_q == 2'b00) ? CNT_W'(NQ - 1) : CNT_W'(NEU_OUT - 1);
    assign out_s.valid = (state_q == S_DRAIN);
    assign out_s.data  = pe_q[q_idx*WORD_LEN +: WORD_LEN];
    assign out_s.last  = (state_q == S_DRAIN) && (cnt_q == last_idx);
    assign out_hs      = out_s.valid && out_s.ready;

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign pe_ce   = (state_q == S_FIRE);
    assign pe_mode = mode_q;
    assign pe_d    = pe_d_q;
    assign pe_w    = pe_w_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        reuse_d = reuse_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_D;
                    cnt_d   = '0;
                    mode_d  = mode_in;
                    reuse_d = reuse_w;
                end
            end
            S_LOAD_D: begin
                if (in_hs) begin
                    if (cnt_q == CNT_W'(NEU_IN - 1)) begin
                        cnt_d   = '0;
                        state_d = reuse_q ? S_FIRE : S_LOAD_W;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_LOAD_W: begin
                if (in_hs) begin
                    if (cnt_q == CNT_W'(NW - 1)) begin
                        cnt_d   = '0;
                        state_d = S_FIRE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FIRE: begin
                if (cnt_q == CNT_W'(PE_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_hs) begin
                    if (out_s.last) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            reuse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            reuse_q <= reuse_d;
            done_q  <= done_d;
        end
    end

    // Words not written by a load keep their value, so W survives reuse jobs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_d_q <= '0;
            pe_w_q <= '0;
        end else if (in_hs) begin
            if (state_q == S_LOAD_D) begin
                pe_d_q[d_idx*WORD_LEN +: WORD_LEN] <= in_s.data;
            end else begin
                pe_w_q[w_idx*WORD_LEN +: WORD_LEN] <= in_s.data;
            end
        end
    end
endmodule

// File: tb/tb_pe_stream_feeder.sv
// Directed bench for pe_stream_feeder: loads, fire timing, drain order and backpressure,
// weight reuse and mid-job reset, with expected outputs held in a scoreboard queue.
module tb_pe_stream_feeder;
    localparam int unsigned WL = 16;
    localparam int unsigned NI = 16;
    localparam int unsigned NO = 4;
    localparam int unsigned PL = 2;
    localparam int unsigned NW = NI * NO;
    localparam int unsigned NQ = NW / 2;

    typedef struct {
        logic [WL-1:0] data;
        logic          last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode_in = 2'b00;
    logic              reuse_w = 1'b0;
    logic              busy, done, pe_ce;
    logic [1:0]        pe_mode;
    logic [WL*NI-1:0]  pe_d;
    logic [WL*NW-1:0]  pe_w;
    logic [WL*NQ-1:0]  pe_q = '0;

    pe_stream_feeder_if #(.WORD_LEN(WL)) in_if ();
    pe_stream_feeder_if #(.WORD_LEN(WL)) out_if ();

    pe_stream_feeder #(
        .WORD_LEN(WL),
        .NEU_IN  (NI),
        .NEU_OUT (NO),
        .PE_LAT  (PL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode_in(mode_in),
        .reuse_w(reuse_w),
        .busy   (busy),
        .done   (done),
        .in_s   (in_if),
        .out_s  (out_if),
        .pe_ce  (pe_ce),
        .pe_mode(pe_mode),
        .pe_d   (pe_d),
        .pe_w   (pe_w),
        .pe_q   (pe_q)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    exp_t          sb[$];
    logic [WL-1:0] exp_d[NI];
    logic [WL-1:0] exp_w[NW];
    int            ce_cnt = 0;
    int            hs_mon = 0;
    logic [1:0]    cur_mode = 2'b00;
    logic          exp_done = 1'b0;
    logic          bp_en = 1'b0;
    logic          stall_q = 1'b0;
    logic [WL-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NI; k++) exp_d[k] = '0;
        for (int k = 0; k < NW; k++) exp_w[k] = '0;
        sb.delete();
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_in_ready"}, 32'(in_if.ready), 0);
        chk({p, "_out_valid"}, 32'(out_if.valid), 0);
        chk({p, "_out_last"}, 32'(out_if.last), 0);
        chk({p, "_pe_ce"}, 32'(pe_ce), 0);
        chk({p, "_done"}, 32'(done), 0);
        chk({p, "_pe_mode"}, 32'(pe_mode), 0);
        for (int k = 0; k < NI; k++) chk({p, "_pe_d"}, 32'(pe_d[k*WL +: WL]), 0);
        for (int k = 0; k < NW; k++) chk({p, "_pe_w"}, 32'(pe_w[k*WL +: WL]), 0);
    endtask

    task automatic do_start(input logic [1:0] m, input logic ru);
        exp_t e;
        int   nexp;
        @(posedge clk); #1;
        for (int i = 0; i < NQ / 2; i++) pe_q[i*32 +: 32] = $urandom;
        nexp = (m == 2'b00) ? NQ : NO;
        for (int j = 0; j < nexp; j++) begin
            e.data = pe_q[j*WL +: WL];
            e.last = (j == nexp - 1);
            sb.push_back(e);
        end
        ce_cnt   = 0;
        hs_mon   = 0;
        cur_mode = m;
        start    = 1'b1;
        mode_in  = m;
        reuse_w  = ru;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic tw, input int n, input logic [WL-1:0] base, input logic gaps);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 4000) begin
            in_if.valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_if.data  = base + WL'(k);
            @(negedge clk);
            if (in_if.valid && in_if.ready) begin
                if (tw) exp_w[k] = in_if.data;
                else exp_d[k] = in_if.data;
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_if.valid = 1'b0;
        if (k < n) chk("feed_timeout", 32'(k), 32'(n));
    endtask

    task automatic wait_done();
        int cyc = 0;
        @(negedge clk);
        while (done !== 1'b1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 32'(done), 1);
    endtask

    task automatic run_job(input logic [1:0] m, input logic ru, input logic [WL-1:0] db,
                           input logic [WL-1:0] wb, input logic gaps, input logic poke);
        do_start(m, ru);
        feed(1'b0, NI, db, gaps);
        if (!ru) feed(1'b1, NW, wb, gaps);
        @(negedge clk);
        chk("in_ready_after_load", 32'(in_if.ready), 0);
        chk("pe_ce_after_load", 32'(pe_ce), 1);
        for (int k = 0; k < NI; k++) chk("pe_d_word", 32'(pe_d[k*WL +: WL]), 32'(exp_d[k]));
        for (int k = 0; k < NW; k++) chk("pe_w_word", 32'(pe_w[k*WL +: WL]), 32'(exp_w[k]));
        if (poke) begin
            // A start while busy must not relaunch or change the latched mode.
            @(posedge clk); #1;
            start   = 1'b1;
            mode_in = ~m;
            reuse_w = ~ru;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done();
        chk("in_handshakes", 32'(hs_mon), ru ? 32'(NI) : 32'(NI + NW));
        chk("ce_cycles", 32'(ce_cnt), 32'(PL));
        chk("sb_empty", 32'(sb.size()), 0);
        chk("pe_mode_idle", 32'(pe_mode), 32'(m));
    endtask

    task automatic reset_now(input string p);
        rst_n = 1'b0;
        #1;
        clear_model();
        chk_reset(p);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Downstream ready: always 1, or the 1,0,0,1,0,1 pattern under backpressure.
    initial begin
        logic pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int   pidx = 0;
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_if.ready = bp_en ? pat[pidx] : 1'b1;
            pidx = (pidx + 1) % 6;
        end
    end

    // Output monitor: pops the scoreboard on each handshake and checks holds and done timing.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_q  = 1'b0;
                exp_done = 1'b0;
            end else begin
                chk("done_pulse", 32'(done), 32'(exp_done));
                exp_done = 1'b0;
                if (pe_ce) begin
                    ce_cnt++;
                    chk("pe_mode_fire", 32'(pe_mode), 32'(cur_mode));
                end
                if (in_if.valid && in_if.ready) hs_mon++;
                if (stall_q) begin
                    chk("out_data_hold", 32'(out_if.data), 32'(prev_data));
                    chk("out_last_hold", 32'(out_if.last), 32'(prev_last));
                end
                if (out_if.valid && out_if.ready) begin
                    stall_q = 1'b0;
                    chk("sb_nonempty", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("out_data", 32'(out_if.data), 32'(e.data));
                        chk("out_last", 32'(out_if.last), 32'(e.last));
                        if (e.last) exp_done = 1'b1;
                    end
                end else if (out_if.valid) begin
                    stall_q   = 1'b1;
                    prev_data = out_if.data;
                    prev_last = out_if.last;
                end else begin
                    stall_q = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_if.valid = 1'b0;
        in_if.data  = '0;
        in_if.last  = 1'b0;
        clear_model();

        // Power-on reset.
        #1;
        chk_reset("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode 01, full load.
        run_job(2'b01, 1'b0, 16'h0001, 16'h0100, 1'b0, 1'b0);
        chk("pe_d_word5", 32'(pe_d[5*WL +: WL]), 32'h0006);
        chk("pe_w_word63", 32'(pe_w[63*WL +: WL]), 32'h013F);

        // Mode 00, full load.
        run_job(2'b00, 1'b0, 16'h0001, 16'h0100, 1'b0, 1'b0);

        // Weight reuse: only D is streamed.
        run_job(2'b10, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b0);
        chk("reuse_pe_w63", 32'(pe_w[63*WL +: WL]), 32'h013F);

        // Input gaps, output backpressure, ignored start while busy.
        bp_en = 1'b1;
        run_job(2'b00, 1'b0, 16'h0A00, 16'h0B00, 1'b1, 1'b1);
        run_job(2'b11, 1'b0, 16'h0C00, 16'h0D00, 1'b1, 1'b1);
        bp_en = 1'b0;

        // Reset in the middle of random input traffic.
        do_start(2'b00, 1'b0);
        feed(1'b0, 10, 16'h0500, 1'b1);
        in_if.valid = 1'b1;
        in_if.data  = 16'hDEAD;
        reset_now("rst_mid");
        hs_mon = 0;
        repeat (10) begin
            @(posedge clk); #1;
            in_if.valid = 1'($urandom_range(0, 1));
        end
        in_if.valid = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_hs", 32'(hs_mon), 0);
        chk("post_rst_out_valid", 32'(out_if.valid), 0);

        // Abort during the weight load, then a clean mode 01 job.
        do_start(2'b01, 1'b0);
        feed(1'b0, NI, 16'h0700, 1'b0);
        feed(1'b1, 30, 16'h0800, 1'b0);
        reset_now("abort");
        run_job(2'b01, 1'b0, 16'h0001, 16'h0100, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
